// File: rtl/decode_pkg.sv
// Shared constants and the ID/EX payload type for the pipelined MIPS decode stage.
// The forwarding option is selected with the DECODE_BYPASS_EN macro (see regfile_p).
package decode_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_IMM_W    = 16;

  // MIPS R/I-format register field positions
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  // ID/EX payload at the default widths; the stage builds a parameter-sized twin.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] register_rs;
    logic [DEF_DATA_W-1:0] register_rt;
    logic [DEF_DATA_W-1:0] imm_ext;
    logic [DEF_ADDR_W-1:0] wreg_rd;
    logic [DEF_ADDR_W-1:0] wreg_rt;
    logic [DEF_ADDR_W-1:0] wreg_rs;
  } id_ex_t;

endpackage

// File: rtl/decode_stage_p_if.sv
// Bus between fetch/write-back and the decode stage, plus the ID/EX outputs.
interface decode_stage_p_if
  import decode_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  // Handshake: an instruction is accepted on a rising clock edge when
  // in_valid && in_ready; in_ready is simply !stall. out_valid marks the
  // ID/EX register as holding a real instruction (no downstream back-pressure).
  logic              in_valid;
  logic              in_ready;
  logic              stall;
  logic              flush;
  logic [31:0]       instruction;
  logic              zero_ext;
  logic [DATA_W-1:0] memory_data;
  logic [DATA_W-1:0] alu_result;
  logic              regwrite;
  logic              memtoreg;
  logic [ADDR_W-1:0] wreg_address;
  logic              out_valid;
  logic [DATA_W-1:0] register_rs;
  logic [DATA_W-1:0] register_rt;
  logic [DATA_W-1:0] imm_ext;
  logic [ADDR_W-1:0] wreg_rd;
  logic [ADDR_W-1:0] wreg_rt;
  logic [ADDR_W-1:0] wreg_rs;

  modport master (
    output in_valid, stall, flush, instruction, zero_ext,
           memory_data, alu_result, regwrite, memtoreg, wreg_address,
    input  in_ready, out_valid, register_rs, register_rt, imm_ext,
           wreg_rd, wreg_rt, wreg_rs
  );

  modport slave (
    input  in_valid, stall, flush, instruction, zero_ext,
           memory_data, alu_result, regwrite, memtoreg, wreg_address,
    output in_ready, out_valid, register_rs, register_rt, imm_ext,
           wreg_rd, wreg_rt, wreg_rs
  );

endinterface

// File: rtl/decode_stage_p_regfile.sv
// NUM_REGS x DATA_W register file: reset to index values, r0 hardwired to zero.
// Define DECODE_BYPASS_EN to forward the write port into same-cycle reads.
module regfile_p
  import decode_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_en;

  assign wr_en = we && (waddr != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= DATA_W'(i);
      end
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rs_data = (rs_addr == '0) ? '0 : regs[rs_addr];
    rt_data = (rt_addr == '0) ? '0 : regs[rt_addr];
`ifdef DECODE_BYPASS_EN
    // wr_en already excludes r0, so r0 is never forwarded
    if (wr_en && (waddr == rs_addr)) rs_data = wdata;
    if (wr_en && (waddr == rt_addr)) rt_data = wdata;
`endif
  end

endmodule

// File: rtl/decode_stage_p.sv
// Pipelined MIPS decode: register file, write-back mux, immediate extender and
// ID/EX register with stall/flush. Optional forwarding via DECODE_BYPASS_EN.
module decode_stage_p
  import decode_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int IMM_W    = DEF_IMM_W
) (
  input logic             clock,
  input logic             reset,
  decode_stage_p_if.slave bus
);

  typedef struct packed {
    logic [DATA_W-1:0] register_rs;
    logic [DATA_W-1:0] register_rt;
    logic [DATA_W-1:0] imm_ext;
    logic [ADDR_W-1:0] wreg_rd;
    logic [ADDR_W-1:0] wreg_rt;
    logic [ADDR_W-1:0] wreg_rs;
  } payload_t;

  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] write_data;
  logic [IMM_W-1:0]  imm;
  payload_t          payload_d;
  payload_t          payload_q;
  logic              valid_q;
  logic              unused_opcode;

  // Register fields are resized to ADDR_W (truncate or zero-extend)
  assign rs_addr    = ADDR_W'(bus.instruction[RS_HI:RS_LO]);
  assign rt_addr    = ADDR_W'(bus.instruction[RT_HI:RT_LO]);
  assign write_data = bus.memtoreg ? bus.memory_data : bus.alu_result;
  assign imm        = bus.instruction[IMM_W-1:0];
  assign unused_opcode = ^bus.instruction;

  regfile_p #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W)
  ) u_regfile (
    .clock  (clock),
    .reset  (reset),
    .rs_addr(rs_addr),
    .rt_addr(rt_addr),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .we     (bus.regwrite),
    .waddr  (bus.wreg_address),
    .wdata  (write_data)
  );

  always_comb begin
    payload_d             = '0;
    payload_d.register_rs = rs_data;
    payload_d.register_rt = rt_data;
    payload_d.imm_ext     = bus.zero_ext ? DATA_W'(imm)
                                         : {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    payload_d.wreg_rd     = ADDR_W'(bus.instruction[RD_HI:RD_LO]);
    payload_d.wreg_rt     = rt_addr;
    payload_d.wreg_rs     = rs_addr;
  end

  // Flush only clears valid; the payload is left as-is as a don't-care bubble
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      payload_q <= '0;
      valid_q   <= 1'b0;
    end else if (bus.flush) begin
      valid_q   <= 1'b0;
    end else if (!bus.stall) begin
      payload_q <= payload_d;
      valid_q   <= bus.in_valid;
    end
  end

  assign bus.in_ready    = !bus.stall;
  assign bus.out_valid   = valid_q;
  assign bus.register_rs = payload_q.register_rs;
  assign bus.register_rt = payload_q.register_rt;
  assign bus.imm_ext     = payload_q.imm_ext;
  assign bus.wreg_rd     = payload_q.wreg_rd;
  assign bus.wreg_rt     = payload_q.wreg_rt;
  assign bus.wreg_rs     = payload_q.wreg_rs;

endmodule

// File: tb/tb_decode_stage_p.sv
// Bench for decode_stage_p: directed literal checks, then random traffic
// checked every cycle against a behavioural register-file/pipeline model.
module tb_decode_stage_p;
  import decode_pkg::*;

`ifdef DECODE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  decode_stage_p_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  decode_stage_p #(
    .DATA_W(32), .NUM_REGS(32), .ADDR_W(5), .IMM_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mregs [32];
  id_ex_t      exp_p;
  logic        exp_v;
  logic [31:0] m_wd;
  logic        m_wr;
  logic [4:0]  m_wa;
  logic [15:0] m_imm;

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (BYPASS && m_wr && (a == m_wa)) return m_wd;
    return mregs[a];
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mregs[i] = i;
      exp_p = '0;
      exp_v = 1'b0;
    end else begin
      m_wa  = bus.wreg_address;
      m_wd  = bus.memtoreg ? bus.memory_data : bus.alu_result;
      m_wr  = bus.regwrite && (m_wa != 5'd0);
      m_imm = bus.instruction[15:0];
      if (bus.flush) begin
        exp_v = 1'b0;
      end else if (!bus.stall) begin
        exp_v             = bus.in_valid;
        exp_p.register_rs = model_read(bus.instruction[25:21]);
        exp_p.register_rt = model_read(bus.instruction[20:16]);
        exp_p.imm_ext     = bus.zero_ext ? 32'(m_imm) : 32'($signed(m_imm));
        exp_p.wreg_rd     = bus.instruction[15:11];
        exp_p.wreg_rt     = bus.instruction[20:16];
        exp_p.wreg_rs     = bus.instruction[25:21];
      end
      if (m_wr) mregs[m_wa] = m_wd;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    if (chk_en) begin
      check("in_ready",    32'(bus.in_ready),  32'(!bus.stall));
      check("out_valid",   32'(bus.out_valid), 32'(exp_v));
      check("register_rs", bus.register_rs,    exp_p.register_rs);
      check("register_rt", bus.register_rt,    exp_p.register_rt);
      check("imm_ext",     bus.imm_ext,        exp_p.imm_ext);
      check("wreg_rd",     32'(bus.wreg_rd),   32'(exp_p.wreg_rd));
      check("wreg_rt",     32'(bus.wreg_rt),   32'(exp_p.wreg_rt));
      check("wreg_rs",     32'(bus.wreg_rs),   32'(exp_p.wreg_rs));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.in_valid     = 1'b0;
    bus.stall        = 1'b0;
    bus.flush        = 1'b0;
    bus.instruction  = 32'd0;
    bus.zero_ext     = 1'b0;
    bus.memory_data  = 32'd0;
    bus.alu_result   = 32'd0;
    bus.regwrite     = 1'b0;
    bus.memtoreg     = 1'b0;
    bus.wreg_address = 5'd0;
  endtask

  function automatic logic [31:0] mk_instr(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [15:0] imm);
    return {6'd0, rs, rt, imm};
  endfunction

  task automatic next_cycle();
    @(negedge clock);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    #1 reset = 1'b1;
    next_cycle();
    next_cycle();
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_rs",        bus.register_rs,    32'd0);
    check("reset_imm",       bus.imm_ext,        32'd0);
    reset  = 1'b0;
    chk_en = 1'b1;

    // basic read of reset-initialised registers
    bus.in_valid    = 1'b1;
    bus.instruction = mk_instr(5'd3, 5'd7, 16'h0000);
    next_cycle();
    check("basic_valid", 32'(bus.out_valid), 32'd1);
    check("basic_rs",    bus.register_rs,    32'd3);
    check("basic_rt",    bus.register_rt,    32'd7);

    // immediate extension
    bus.instruction = mk_instr(5'd1, 5'd2, 16'h8001);
    bus.zero_ext    = 1'b0;
    next_cycle();
    check("imm_sign", bus.imm_ext, 32'hFFFF8001);
    bus.zero_ext = 1'b1;
    next_cycle();
    check("imm_zero", bus.imm_ext, 32'h00008001);
    bus.zero_ext = 1'b0;

    // write-back from memory with same-cycle read
    bus.regwrite     = 1'b1;
    bus.memtoreg     = 1'b1;
    bus.memory_data  = 32'hDEADBEEF;
    bus.wreg_address = 5'd5;
    bus.instruction  = mk_instr(5'd5, 5'd0, 16'h0000);
    next_cycle();
    check("wb_same_cycle", bus.register_rs, BYPASS ? 32'hDEADBEEF : 32'd5);
    bus.regwrite = 1'b0;
    next_cycle();
    check("wb_next_cycle", bus.register_rs, 32'hDEADBEEF);

    // writes to r0 are ignored
    bus.regwrite     = 1'b1;
    bus.memtoreg     = 1'b0;
    bus.alu_result   = 32'h1234;
    bus.wreg_address = 5'd0;
    bus.instruction  = mk_instr(5'd0, 5'd0, 16'h0000);
    next_cycle();
    check("r0_same_cycle", bus.register_rs, 32'd0);
    bus.regwrite = 1'b0;
    next_cycle();
    check("r0_after", bus.register_rs, 32'd0);

    // stall holds, flush beats stall
    bus.instruction = mk_instr(5'd1, 5'd2, 16'h0042);
    next_cycle();
    check("pre_stall_rs", bus.register_rs, 32'd1);
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.instruction = mk_instr(5'(10 + k), 5'(20 + k), 16'(k));
      next_cycle();
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_rs",    bus.register_rs,    32'd1);
      check("stall_imm",   bus.imm_ext,        32'h42);
    end
    bus.flush = 1'b1;
    next_cycle();
    check("flush_stall_valid", 32'(bus.out_valid), 32'd0);
    check("flush_hold_rs",     bus.register_rs,    32'd1);
    bus.stall = 1'b0;
    bus.flush = 1'b0;

    // async reset mid-cycle wipes a completed write
    bus.regwrite     = 1'b1;
    bus.alu_result   = 32'hAA;
    bus.wreg_address = 5'd9;
    next_cycle();
    bus.regwrite    = 1'b0;
    bus.instruction = mk_instr(5'd9, 5'd0, 16'h0000);
    next_cycle();
    check("reg9_written", bus.register_rs, 32'hAA);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_rs",    bus.register_rs,    32'd0);
    next_cycle();
    reset = 1'b0;
    next_cycle();
    check("reg9_reset", bus.register_rs, 32'd9);

    // randomized traffic, checked by the compare process
    for (int c = 0; c < 400; c++) begin
      bus.in_valid     = 1'($urandom_range(0, 1));
      bus.stall        = ($urandom_range(0, 9) < 2);
      bus.flush        = ($urandom_range(0, 9) == 0);
      bus.instruction  = $urandom;
      bus.zero_ext     = 1'($urandom_range(0, 1));
      bus.memory_data  = $urandom;
      bus.alu_result   = $urandom;
      bus.regwrite     = ($urandom_range(0, 9) < 7);
      bus.memtoreg     = 1'($urandom_range(0, 1));
      bus.wreg_address = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) bus.instruction[25:21] = bus.wreg_address;
      if ($urandom_range(0, 3) == 0) bus.instruction[20:16] = bus.wreg_address;
      next_cycle();
    end

    idle();
    next_cycle();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage_p.md
Name: decode_stage_p

Overview:
Parametrised successor to the single-cycle MIPS instruction-decode unit.
- Holds a NUM_REGS x DATA_W register file and performs the memtoreg write-back mux.
- Produces rs/rt operands, an extended immediate and the candidate destinations.
- Unlike the combinational predecessor, outputs are registered in an ID/EX pipeline register with valid/stall/flush control.
- Sits between fetch and execute in the pipelined datapath.

Parameters:
DATA_W, 32, register and datapath width
NUM_REGS, 32, number of architectural registers; power of two, >= 2
ADDR_W, 5, register address width; must equal clog2(NUM_REGS)
IMM_W, 16, immediate field width taken from instruction[IMM_W-1:0]; must be < DATA_W

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  instruction bus carries a valid instruction
in_ready  out  1  stage accepts a new instruction this cycle (= !stall)
stall  in  1  hold ID/EX register contents
flush  in  1  squash ID/EX contents (bubble)
instruction  in  32  MIPS instruction word
zero_ext  in  1  1 = zero-extend immediate, 0 = sign-extend
memory_data  in  DATA_W  write-back data from memory
alu_result  in  DATA_W  write-back data from ALU
regwrite  in  1  write-back enable
memtoreg  in  1  1 selects memory_data, 0 selects alu_result
wreg_address  in  ADDR_W  write-back destination
out_valid  out  1  ID/EX register holds a valid instruction
register_rs  out  DATA_W  registered rs operand
register_rt  out  DATA_W  registered rt operand
imm_ext  out  DATA_W  registered extended immediate
wreg_rd  out  ADDR_W  registered instruction[15:11] (upper bits zero if ADDR_W > 5)
wreg_rt  out  ADDR_W  registered instruction[20:16]
wreg_rs  out  ADDR_W  registered instruction[25:21]

Behaviour:
Reset:
- reset asserted: register[i] <= i (truncated to DATA_W) for all i, asynchronously.
- All ID/EX outputs go to 0, including out_valid.
- Reset mid-operation discards any in-flight write and pipeline contents.

Register file:
- write_data = memtoreg ? memory_data : alu_result.
- At posedge clock, if regwrite && wreg_address != 0, then register[wreg_address] <= write_data.
- Register 0 always reads 0; writes to it are ignored.
- Reads use instruction[25:21] and instruction[20:16], truncated or zero-extended to ADDR_W.

Immediate:
- imm_ext = zero_ext ? zero-extended imm : sign-extended imm (replicate bit IMM_W-1).

ID/EX register (latency 1 cycle), evaluated at each posedge in this priority order:
1. flush: out_valid <= 0; payload holds.
2. stall: all outputs hold.
3. Otherwise: capture operands, imm_ext and wreg_* fields; out_valid <= in_valid.
- Payload is captured even when in_valid = 0 (don't-care).
- flush && stall together: flush wins, so out_valid becomes 0.
- Write-back is never stalled: regwrite is honoured during stall and flush.

Optional Feature:
Macro DECODE_BYPASS_EN, write-to-read forwarding.
- Defined: if regwrite && wreg_address != 0 && wreg_address matches a read address, that operand takes write_data in the same cycle, so the ID/EX register captures the new value.
- Undefined: the operand reads the old array value; the write is visible to reads from the next cycle onward.
- Register 0 is never forwarded in either case.

Decomposition:
- Package decode_pkg holds:
  - instruction field bit-position constants (RS_HI/LO, RT_HI/LO, RD_HI/LO);
  - default DATA_W, NUM_REGS and IMM_W;
  - a typedef for the ID/EX payload struct.
- One natural sub-module: regfile_p (array, async reset init, write port, zero register, optional bypass). decode_stage_p adds the mux, extender and pipeline register.

Test Plan:
- Reset, then instruction rs=3, rt=7, in_valid=1 -> next cycle out_valid=1, register_rs=3, register_rt=7.
- imm 0x8001 with zero_ext=0 -> imm_ext=0xFFFF8001; with zero_ext=1 -> imm_ext=0x00008001.
- regwrite=1, memtoreg=1, memory_data=0xDEADBEEF, wreg_address=5, same-cycle read of rs=5 -> register_rs=0xDEADBEEF with DECODE_BYPASS_EN; 5 without it, then 0xDEADBEEF on the following cycle.
- Write 0x1234 to register 0, then read rs=0 -> register_rs=0.
- stall=1 for 3 cycles while instruction changes -> outputs hold; flush=1 together with stall=1 -> out_valid=0 next cycle.
- Assert reset asynchronously mid-cycle after writing register 9=0xAA -> outputs 0 immediately; register 9 reads back 9.
